count_monitor: RTL and testbench



---
 rtl/count_monitor.sv | 160 ++++++++++++++++
 tb/tb_count_monitor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/count_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : count_monitor
//  Description : Watches the value stream of an 8-bit up/down counter, locks
//                onto its counting direction and flags protocol violations
//                (jumps, over-long holds) and wrap-around events.
//  Revision    : 1.0 - initial release
// ============================================================================
module count_monitor #(
   parameter int HOLD_MAX = 4,  // unchanged samples tolerated while locked
   parameter int LOCK_N   = 2   // same-direction steps needed to lock
) (
   input  logic       clk,
   input  logic       reset,     // synchronous, active-low
   input  logic [7:0] Qin,
   input  logic       valid,
   output logic       dir_out,
   output logic       locked,
   output logic       err,
   output logic       wrap_up,
   output logic       wrap_down,
   output logic [7:0] err_count
);

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [7:0] C_LOCK_N   = 8'(LOCK_N);
   localparam logic [7:0] C_HOLD_MAX = 8'(HOLD_MAX);
   localparam logic [7:0] C_SAT      = 8'hFF;

   state_t     state_q, state_d;
   logic [7:0] prev_q, prev_d;
   logic [7:0] run_q, run_d;
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic [7:0] err_count_q, err_count_d;
   logic       dir_q, dir_d;
   logic       err_q, err_d;
   logic       wrap_up_q, wrap_up_d;
   logic       wrap_down_q, wrap_down_d;

   // Step classification of the incoming sample against the held value
   logic [7:0] w_delta;
   logic       w_up, w_down, w_hold, w_step;
   logic [7:0] w_run_inc, w_hold_inc;

   assign w_delta    = Qin - prev_q;
   assign w_up       = (w_delta == 8'd1);
   assign w_down     = (w_delta == 8'hFF);
   assign w_hold     = (w_delta == 8'd0);
   assign w_step     = w_up | w_down;
   assign w_run_inc  = (run_q == C_SAT) ? run_q : run_q + 8'd1;
   assign w_hold_inc = (hold_cnt_q == C_SAT) ? hold_cnt_q : hold_cnt_q + 8'd1;

   // Next-state computation; nothing moves unless a valid sample arrives
   always_comb begin
      logic run_tmp;
      logic fault;
      state_d     = state_q;
      prev_d      = prev_q;
      run_d       = run_q;
      hold_cnt_d  = hold_cnt_q;
      dir_d       = dir_q;
      err_count_d = err_count_q;
      err_d       = 1'b0;
      wrap_up_d   = 1'b0;
      wrap_down_d = 1'b0;
      run_tmp     = 1'b0;
      fault       = 1'b0;

      if (valid) begin
         prev_d = Qin;
         // Wrap pulses apply to any legal step once a previous value exists
         if (state_q != ST_EMPTY) begin
            wrap_up_d   = w_up   && (prev_q == 8'hFF);
            wrap_down_d = w_down && (prev_q == 8'h00);
         end

         case (state_q)
            ST_EMPTY: begin
               state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               if (w_step) begin
                  run_tmp = (w_up == dir_q);
                  run_d   = run_tmp ? w_run_inc : 8'd1;
                  dir_d   = w_up;
                  if ((run_tmp ? w_run_inc : 8'd1) >= C_LOCK_N) begin
                     state_d    = ST_LOCKED;
                     run_d      = 8'd0;
                     hold_cnt_d = 8'd0;
                  end
               end else if (!w_hold) begin
                  run_d = 8'd0;   // jump restarts acquisition silently
               end
            end
            ST_LOCKED: begin
               if (w_step) begin
                  hold_cnt_d = 8'd0;
                  dir_d      = w_up;   // same direction or legal reversal
               end else if (w_hold) begin
                  hold_cnt_d = w_hold_inc;
                  fault      = (w_hold_inc > C_HOLD_MAX);
               end else begin
                  fault = 1'b1;
               end
               if (fault) begin
                  err_d       = 1'b1;
                  err_count_d = (err_count_q == C_SAT) ? err_count_q
                                                       : err_count_q + 8'd1;
                  state_d     = ST_ACQUIRE;
                  run_d       = 8'd0;
                  hold_cnt_d  = 8'd0;
                  dir_d       = dir_q;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_EMPTY;
         prev_q      <= 8'd0;
         run_q       <= 8'd0;
         hold_cnt_q  <= 8'd0;
         dir_q       <= 1'b1;
         err_count_q <= 8'd0;
         err_q       <= 1'b0;
         wrap_up_q   <= 1'b0;
         wrap_down_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         run_q       <= run_d;
         hold_cnt_q  <= hold_cnt_d;
         dir_q       <= dir_d;
         err_count_q <= err_count_d;
         err_q       <= err_d;
         wrap_up_q   <= wrap_up_d;
         wrap_down_q <= wrap_down_d;
      end
   end

   assign dir_out   = dir_q;
   assign locked    = (state_q == ST_LOCKED);
   assign err       = err_q;
   assign wrap_up   = wrap_up_q;
   assign wrap_down = wrap_down_q;
   assign err_count = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_count_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_monitor
//  Description : Directed self-checking bench for count_monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_monitor;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] Qin;
   logic       valid;
   logic       dir_out, locked, err, wrap_up, wrap_down;
   logic [7:0] err_count;

   int checks   = 0;
   int failures = 0;

   count_monitor #(.HOLD_MAX(4), .LOCK_N(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .Qin       (Qin),
      .valid     (valid),
      .dir_out   (dir_out),
      .locked    (locked),
      .err       (err),
      .wrap_up   (wrap_up),
      .wrap_down (wrap_down),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Present one valid sample; returns #1 after the consuming edge
   task automatic send(input logic [7:0] v);
      Qin   = v;
      valid = 1'b1;
      @(posedge clk);
      #1;
      valid = 1'b0;
   endtask

   task automatic idle(input int n);
      valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_dir"},    {7'd0, dir_out},   8'd1);
      chk({tag, "_locked"}, {7'd0, locked},    8'd0);
      chk({tag, "_err"},    {7'd0, err},       8'd0);
      chk({tag, "_wup"},    {7'd0, wrap_up},   8'd0);
      chk({tag, "_wdn"},    {7'd0, wrap_down}, 8'd0);
      chk({tag, "_ecnt"},   err_count,         8'd0);
   endtask

   initial begin
      logic [7:0] v;
      reset = 1'b0;
      valid = 1'b0;
      Qin   = 8'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_reset_state("rst");
      reset = 1'b1;

      // Lock upward on 10, 11, 12
      send(8'd10);
      chk("first_locked", {7'd0, locked}, 8'd0);
      chk("first_err",    {7'd0, err},    8'd0);
      send(8'd11);
      chk("acq_locked",   {7'd0, locked}, 8'd0);
      send(8'd12);
      chk("lock_locked",  {7'd0, locked}, 8'd1);
      chk("lock_dir",     {7'd0, dir_out}, 8'd1);
      chk("lock_ecnt",    err_count,       8'd0);

      // Reset while locked; 251 is then a first sample, not a jump
      do_reset();
      chk("rst2_locked", {7'd0, locked}, 8'd0);
      send(8'd251);
      chk("rst2_err",    {7'd0, err},    8'd0);
      send(8'd252);
      send(8'd253);
      chk("wrapset_locked", {7'd0, locked}, 8'd1);
      send(8'd254);
      chk("w254_wup", {7'd0, wrap_up}, 8'd0);
      send(8'd255);
      chk("w255_wup", {7'd0, wrap_up}, 8'd0);
      send(8'd0);
      chk("w0_wup",    {7'd0, wrap_up},   8'd1);
      chk("w0_wdn",    {7'd0, wrap_down}, 8'd0);
      chk("w0_err",    {7'd0, err},       8'd0);
      chk("w0_locked", {7'd0, locked},    8'd1);
      send(8'd1);
      chk("w1_wup", {7'd0, wrap_up}, 8'd0);

      // Legal reversal while locked
      do_reset();
      send(8'd18);
      send(8'd19);
      send(8'd20);
      chk("rev_pre_locked", {7'd0, locked}, 8'd1);
      send(8'd19);
      chk("rev_dir",    {7'd0, dir_out}, 8'd0);
      chk("rev_locked", {7'd0, locked},  8'd1);
      chk("rev_err",    {7'd0, err},     8'd0);
      send(8'd18);
      chk("rev2_dir",    {7'd0, dir_out}, 8'd0);
      chk("rev2_locked", {7'd0, locked},  8'd1);

      // Jump while locked, then relock
      do_reset();
      send(8'd48);
      send(8'd49);
      send(8'd50);
      send(8'd57);
      chk("jump_err",    {7'd0, err},    8'd1);
      chk("jump_ecnt",   err_count,      8'd1);
      chk("jump_locked", {7'd0, locked}, 8'd0);
      idle(1);
      chk("jump_err_pulse", {7'd0, err}, 8'd0);
      send(8'd58);
      chk("relock1_locked", {7'd0, locked}, 8'd0);
      send(8'd59);
      chk("relock2_locked", {7'd0, locked},  8'd1);
      chk("relock2_dir",    {7'd0, dir_out}, 8'd1);
      chk("relock2_ecnt",   err_count,       8'd1);

      // Holds while locked, with idle gaps; fifth repeat is the violation
      do_reset();
      send(8'd3);
      send(8'd4);
      send(8'd5);
      for (int i = 1; i <= 4; i++) begin
         idle(2);
         send(8'd5);
         chk($sformatf("hold%0d_err", i),    {7'd0, err},    8'd0);
         chk($sformatf("hold%0d_locked", i), {7'd0, locked}, 8'd1);
      end
      idle(3);
      chk("gap_locked", {7'd0, locked}, 8'd1);
      chk("gap_ecnt",   err_count,      8'd0);
      send(8'd5);
      chk("hold5_err",    {7'd0, err},    8'd1);
      chk("hold5_locked", {7'd0, locked}, 8'd0);
      chk("hold5_ecnt",   err_count,      8'd1);

      // Wrap down on the locking sample, then a plain down step
      do_reset();
      send(8'd1);
      send(8'd0);
      chk("dn_acq_dir", {7'd0, dir_out}, 8'd0);
      send(8'd255);
      chk("dnlock_locked", {7'd0, locked},    8'd1);
      chk("dnlock_wdn",    {7'd0, wrap_down}, 8'd1);
      chk("dnlock_dir",    {7'd0, dir_out},   8'd0);
      chk("dnlock_err",    {7'd0, err},       8'd0);
      send(8'd254);
      chk("dn254_wdn", {7'd0, wrap_down}, 8'd0);

      // Saturate the error counter with 256 jumps, relocking between them
      do_reset();
      send(8'd0);
      send(8'd1);
      send(8'd2);
      v = 8'd2;
      for (int i = 0; i < 256; i++) begin
         v = v + 8'd50;
         send(v);
         if (i == 254) chk("sat_ecnt_255th", err_count, 8'd255);
         v = v + 8'd1;
         send(v);
         v = v + 8'd1;
         send(v);
      end
      chk("sat_ecnt",   err_count,      8'd255);
      chk("sat_locked", {7'd0, locked}, 8'd1);

      // Reset wins over a concurrent valid sample
      reset = 1'b0;
      valid = 1'b1;
      Qin   = 8'd9;
      @(posedge clk);
      #1;
      chk_reset_state("rstv");
      reset = 1'b1;
      valid = 1'b0;
      send(8'd77);
      chk("post_rst_err",    {7'd0, err},    8'd0);
      chk("post_rst_locked", {7'd0, locked}, 8'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
